axi_line_fill_mst: RTL and testbench



---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_line_buf.sv | 38 +++
 rtl/axi_line_fill_mst.sv | 190 +++++++++++++++++++
 tb/tb_axi_line_fill_mst.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and AR/R channel field widths used by the line-fill
// master and its neighbours.
package axi_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_LOCK_W  = 2;
  localparam int AXI_CACHE_W = 2;
  localparam int AXI_PROT_W  = 2;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_4B    = 3'd2;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_line_buf.sv
// LINE_WORDS x 32 line buffer: synchronous clear, one indexed write port and
// a flat read of the whole line (word i at bits [32i+31:32i]).
module axi_line_buf
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_clr,
  input  logic                             i_we,
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [AXI_DATA_W-1:0]            i_wdata,
  output logic [AXI_DATA_W*LINE_WORDS-1:0] o_data
);

  logic [AXI_DATA_W-1:0] r_mem [LINE_WORDS];

  // NOTE: this storage is reset (unlike a RAM) because words not written by a
  // short burst must read back as zero, and a dropped line must never leak.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // reader sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign o_data[AXI_DATA_W*g +: AXI_DATA_W] = r_mem[g];
  end

endmodule

// File: rtl/axi_line_fill_mst.sv
// AXI4 read-burst master for cache-line refill: one INCR burst per request,
// beats collected into a line buffer, whole line returned with an error flag.
// Build option: AXI_LINE_FILL_ID_CHECK_EN flags beats whose rid != ARID.
module axi_line_fill_mst
  import axi_pkg::*;
#(
  parameter int                  LINE_WORDS = 8,
  parameter logic [AXI_ID_W-1:0] ARID       = 4'b0011
) (
  input  logic                             clock,
  input  logic                             reset,

  input  logic                             io_req_valid,
  output logic                             io_req_ready,
  input  logic [AXI_ADDR_W-1:0]            io_req_addr,

  output logic                             io_resp_valid,
  input  logic                             io_resp_ready,
  output logic [AXI_DATA_W*LINE_WORDS-1:0] io_resp_data,
  output logic                             io_resp_err,

  input  logic                             io_axi_mst_ar_chl_ready,
  output logic                             io_axi_mst_ar_chl_valid,
  output logic [AXI_ID_W-1:0]              io_axi_mst_ar_chl_bits_arid,
  output logic [AXI_ADDR_W-1:0]            io_axi_mst_ar_chl_bits_araddr,
  output logic [AXI_SIZE_W-1:0]            io_axi_mst_ar_chl_bits_arsize,
  output logic [AXI_LEN_W-1:0]             io_axi_mst_ar_chl_bits_arlen,
  output logic [AXI_BURST_W-1:0]           io_axi_mst_ar_chl_bits_arbusrt,
  output logic [AXI_LOCK_W-1:0]            io_axi_mst_ar_chl_bits_arlock,
  output logic [AXI_CACHE_W-1:0]           io_axi_mst_ar_chl_bits_arcache,
  output logic [AXI_PROT_W-1:0]            io_axi_mst_ar_chl_bits_arprot,

  output logic                             io_axi_mst_r_chl_ready,
  input  logic                             io_axi_mst_r_chl_valid,
  input  logic [AXI_DATA_W-1:0]            io_axi_mst_r_chl_bits_rdata,
  input  logic [AXI_ID_W-1:0]              io_axi_mst_r_chl_bits_rid,
  input  logic [AXI_RESP_W-1:0]            io_axi_mst_r_chl_bits_rresp,
  input  logic                             io_axi_mst_r_chl_bits_rlast
);

  localparam int                    W         = $clog2(LINE_WORDS);
  localparam logic [AXI_ADDR_W-1:0] LINE_MASK = AXI_ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [W-1:0]          LAST_IDX  = W'(LINE_WORDS - 1);
  localparam logic [AXI_LEN_W-1:0]  BURST_LEN = AXI_LEN_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_RESP
  } state_e;

  state_e                  r_state;
  logic                    r_req_ready;
  logic                    r_ar_valid;
  logic [AXI_ID_W-1:0]     r_arid;
  logic [AXI_ADDR_W-1:0]   r_araddr;
  logic [AXI_SIZE_W-1:0]   r_arsize;
  logic [AXI_LEN_W-1:0]    r_arlen;
  logic [AXI_BURST_W-1:0]  r_arbusrt;
  logic                    r_r_ready;
  logic                    r_resp_valid;
  logic                    r_err;
  logic [W-1:0]            r_cnt;

  logic                    w_req_fire;
  logic                    w_beat;
  logic                    w_id_err;
  logic                    w_beat_err;

  // req_ready and r_ready are only ever high in IDLE and R respectively, so
  // these handshakes cannot fire in any other state.
  assign w_req_fire = r_req_ready & io_req_valid;
  assign w_beat     = r_r_ready & io_axi_mst_r_chl_valid;

`ifdef AXI_LINE_FILL_ID_CHECK_EN
  assign w_id_err = (io_axi_mst_r_chl_bits_rid != ARID);
`else
  assign w_id_err = 1'b0 & (|io_axi_mst_r_chl_bits_rid);
`endif

  assign w_beat_err = r_err
                    | (io_axi_mst_r_chl_bits_rresp != AXI_RESP_OKAY)
                    | w_id_err;

  axi_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (W)
  ) u_line_buf (
    .clock   (clock),
    .reset   (reset),
    .i_clr   (w_req_fire),
    .i_we    (w_beat),
    .i_idx   (r_cnt),
    .i_wdata (io_axi_mst_r_chl_bits_rdata),
    .o_data  (io_resp_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_ar_valid   <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arsize     <= '0;
      r_arlen      <= '0;
      r_arbusrt    <= '0;
      r_r_ready    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req_fire) begin
            r_req_ready <= 1'b0;
            r_ar_valid  <= 1'b1;
            r_arid      <= ARID;
            r_araddr    <= io_req_addr & ~LINE_MASK;
            r_arsize    <= AXI_SIZE_4B;
            r_arlen     <= BURST_LEN;
            r_arbusrt   <= AXI_BURST_INCR;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_state     <= ST_AR;
          end
        end

        // AR fields were loaded at request time and are left untouched here,
        // so they stay stable for however long the slave stalls.
        ST_AR: begin
          if (io_axi_mst_ar_chl_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= ST_R;
          end
        end

        ST_R: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_err        <= w_beat_err | ~io_axi_mst_r_chl_bits_rlast;
              r_r_ready    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else if (io_axi_mst_r_chl_bits_rlast) begin
              // Short burst: remaining words keep their cleared value.
              r_err        <= 1'b1;
              r_r_ready    <= 1'b0;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_err <= w_beat_err;
            end
          end
        end

        // req_ready rises together with the return to IDLE, so a request
        // held alongside resp_ready is only taken one cycle later.
        ST_RESP: begin
          if (io_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_req_ready                   = r_req_ready;
  assign io_resp_valid                  = r_resp_valid;
  assign io_resp_err                    = r_err & r_resp_valid;
  assign io_axi_mst_ar_chl_valid        = r_ar_valid;
  assign io_axi_mst_ar_chl_bits_arid    = r_arid;
  assign io_axi_mst_ar_chl_bits_araddr  = r_araddr;
  assign io_axi_mst_ar_chl_bits_arsize  = r_arsize;
  assign io_axi_mst_ar_chl_bits_arlen   = r_arlen;
  assign io_axi_mst_ar_chl_bits_arbusrt = r_arbusrt;
  assign io_axi_mst_ar_chl_bits_arlock  = '0;
  assign io_axi_mst_ar_chl_bits_arcache = '0;
  assign io_axi_mst_ar_chl_bits_arprot  = '0;
  assign io_axi_mst_r_chl_ready         = r_r_ready;

endmodule

// File: tb/tb_axi_line_fill_mst.sv
// Directed bench for axi_line_fill_mst: an inline AXI slave stub returns
// rdata = address and can inject stalls, error responses, early/missing rlast
// and a foreign rid. Inputs change and outputs are sampled on the falling edge.
module tb_axi_line_fill_mst;

  localparam int LW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_req_valid;
  logic            io_req_ready;
  logic [31:0]     io_req_addr;
  logic            io_resp_valid;
  logic            io_resp_ready;
  logic [32*LW-1:0] io_resp_data;
  logic            io_resp_err;
  logic            io_axi_mst_ar_chl_ready;
  logic            io_axi_mst_ar_chl_valid;
  logic [3:0]      io_axi_mst_ar_chl_bits_arid;
  logic [31:0]     io_axi_mst_ar_chl_bits_araddr;
  logic [2:0]      io_axi_mst_ar_chl_bits_arsize;
  logic [3:0]      io_axi_mst_ar_chl_bits_arlen;
  logic [1:0]      io_axi_mst_ar_chl_bits_arbusrt;
  logic [1:0]      io_axi_mst_ar_chl_bits_arlock;
  logic [1:0]      io_axi_mst_ar_chl_bits_arcache;
  logic [1:0]      io_axi_mst_ar_chl_bits_arprot;
  logic            io_axi_mst_r_chl_ready;
  logic            io_axi_mst_r_chl_valid;
  logic [31:0]     io_axi_mst_r_chl_bits_rdata;
  logic [3:0]      io_axi_mst_r_chl_bits_rid;
  logic [1:0]      io_axi_mst_r_chl_bits_rresp;
  logic            io_axi_mst_r_chl_bits_rlast;

  int errors = 0;
  int checks = 0;
  int lat;

  logic [55:0] ctrl_outs;
  logic [51:0] ar_vec;

  assign ctrl_outs = {io_req_ready, io_resp_valid, io_resp_err, io_axi_mst_ar_chl_valid,
                      io_axi_mst_ar_chl_bits_arid, io_axi_mst_ar_chl_bits_araddr,
                      io_axi_mst_ar_chl_bits_arsize, io_axi_mst_ar_chl_bits_arlen,
                      io_axi_mst_ar_chl_bits_arbusrt, io_axi_mst_ar_chl_bits_arlock,
                      io_axi_mst_ar_chl_bits_arcache, io_axi_mst_ar_chl_bits_arprot,
                      io_axi_mst_r_chl_ready};
  assign ar_vec = {io_axi_mst_ar_chl_valid, io_axi_mst_ar_chl_bits_arid,
                   io_axi_mst_ar_chl_bits_araddr, io_axi_mst_ar_chl_bits_arsize,
                   io_axi_mst_ar_chl_bits_arlen, io_axi_mst_ar_chl_bits_arbusrt,
                   io_axi_mst_ar_chl_bits_arlock, io_axi_mst_ar_chl_bits_arcache,
                   io_axi_mst_ar_chl_bits_arprot};

  always #5 clock = ~clock;

  axi_line_fill_mst #(
    .LINE_WORDS (LW),
    .ARID       (4'b0011)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .io_req_valid                   (io_req_valid),
    .io_req_ready                   (io_req_ready),
    .io_req_addr                    (io_req_addr),
    .io_resp_valid                  (io_resp_valid),
    .io_resp_ready                  (io_resp_ready),
    .io_resp_data                   (io_resp_data),
    .io_resp_err                    (io_resp_err),
    .io_axi_mst_ar_chl_ready        (io_axi_mst_ar_chl_ready),
    .io_axi_mst_ar_chl_valid        (io_axi_mst_ar_chl_valid),
    .io_axi_mst_ar_chl_bits_arid    (io_axi_mst_ar_chl_bits_arid),
    .io_axi_mst_ar_chl_bits_araddr  (io_axi_mst_ar_chl_bits_araddr),
    .io_axi_mst_ar_chl_bits_arsize  (io_axi_mst_ar_chl_bits_arsize),
    .io_axi_mst_ar_chl_bits_arlen   (io_axi_mst_ar_chl_bits_arlen),
    .io_axi_mst_ar_chl_bits_arbusrt (io_axi_mst_ar_chl_bits_arbusrt),
    .io_axi_mst_ar_chl_bits_arlock  (io_axi_mst_ar_chl_bits_arlock),
    .io_axi_mst_ar_chl_bits_arcache (io_axi_mst_ar_chl_bits_arcache),
    .io_axi_mst_ar_chl_bits_arprot  (io_axi_mst_ar_chl_bits_arprot),
    .io_axi_mst_r_chl_ready         (io_axi_mst_r_chl_ready),
    .io_axi_mst_r_chl_valid         (io_axi_mst_r_chl_valid),
    .io_axi_mst_r_chl_bits_rdata    (io_axi_mst_r_chl_bits_rdata),
    .io_axi_mst_r_chl_bits_rid      (io_axi_mst_r_chl_bits_rid),
    .io_axi_mst_r_chl_bits_rresp    (io_axi_mst_r_chl_bits_rresp),
    .io_axi_mst_r_chl_bits_rlast    (io_axi_mst_r_chl_bits_rlast)
  );

  task automatic tick();
    @(negedge clock);
    lat++;
  endtask

  task automatic idle_r();
    io_axi_mst_r_chl_valid      = 1'b0;
    io_axi_mst_r_chl_bits_rdata = '0;
    io_axi_mst_r_chl_bits_rid   = 4'b0011;
    io_axi_mst_r_chl_bits_rresp = 2'b00;
    io_axi_mst_r_chl_bits_rlast = 1'b0;
  endtask

  // One full line transaction. last_beat < 0 means rlast is never asserted;
  // err_beat < 0 means every beat is OKAY. exp_lat == 0 skips the latency check.
  task automatic run_line(input string name, input logic [31:0] addr,
                          input logic [31:0] base, input int ar_stall,
                          input int err_beat, input int last_beat,
                          input logic [3:0] rid, input logic exp_err,
                          input int exp_lat, input int resp_hold);
    logic [51:0]      exp_ar;
    logic [32*LW-1:0] exp_data;
    int               nbeats;
    bit               seen;

    nbeats   = (last_beat >= 0) ? last_beat + 1 : LW;
    exp_ar   = {1'b1, 4'b0011, base, 3'd2, 4'd7, 2'b01, 6'b0};
    exp_data = '0;
    for (int i = 0; i < nbeats; i++) begin
      exp_data[32*i +: 32] = base + 32'(4 * i);
    end

    checks++;
    if (io_req_ready !== 1'b1) begin
      $display("FAIL %s req_ready before request: got=%b want=1", name, io_req_ready);
      errors++;
    end

    io_req_valid = 1'b1;
    io_req_addr  = addr;
    lat = 0;
    tick();
    io_req_valid = 1'b0;
    io_req_addr  = '0;

    // Junk R traffic while waiting on AR must be ignored.
    for (int c = 0; c < ar_stall; c++) begin
      io_axi_mst_r_chl_valid      = 1'b1;
      io_axi_mst_r_chl_bits_rdata = 32'hDEAD_BEEF;
      io_axi_mst_r_chl_bits_rresp = 2'b11;
      io_axi_mst_r_chl_bits_rlast = 1'b1;
      checks++;
      if (ar_vec !== exp_ar) begin
        $display("FAIL %s ar fields stall %0d: got=%h want=%h", name, c, ar_vec, exp_ar);
        errors++;
      end
      tick();
    end

    checks++;
    if (ar_vec !== exp_ar) begin
      $display("FAIL %s ar fields at handshake: got=%h want=%h", name, ar_vec, exp_ar);
      errors++;
    end
    io_axi_mst_ar_chl_ready = 1'b1;
    tick();
    io_axi_mst_ar_chl_ready = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      io_axi_mst_r_chl_valid      = 1'b1;
      io_axi_mst_r_chl_bits_rdata = base + 32'(4 * i);
      io_axi_mst_r_chl_bits_rid   = rid;
      io_axi_mst_r_chl_bits_rresp = (i == err_beat) ? 2'b10 : 2'b00;
      io_axi_mst_r_chl_bits_rlast = (i == last_beat);
      checks++;
      if (io_axi_mst_r_chl_ready !== 1'b1) begin
        $display("FAIL %s r_ready beat %0d: got=%b want=1", name, i, io_axi_mst_r_chl_ready);
        errors++;
      end
      tick();
    end
    idle_r();

    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (io_resp_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s resp_valid timeout: got=0 want=1 within 20 cycles", name);
      errors++;
    end
    if (exp_lat > 0) begin
      checks++;
      if (lat !== exp_lat) begin
        $display("FAIL %s resp latency: got=%0d want=%0d", name, lat, exp_lat);
        errors++;
      end
    end

    for (int h = 0; h <= resp_hold; h++) begin
      checks++;
      if ({io_resp_valid, io_resp_err} !== {1'b1, exp_err}) begin
        $display("FAIL %s resp valid/err hold %0d: got=%b%b want=1%b",
                 name, h, io_resp_valid, io_resp_err, exp_err);
        errors++;
      end
      checks++;
      if (io_resp_data !== exp_data) begin
        $display("FAIL %s resp data hold %0d: got=%h want=%h", name, h, io_resp_data, exp_data);
        errors++;
      end
      if (h < resp_hold) tick();
    end

    // A request offered together with resp_ready must not be taken.
    io_resp_ready = 1'b1;
    io_req_valid  = 1'b1;
    io_req_addr   = 32'h5555_0000;
    tick();
    io_resp_ready = 1'b0;
    io_req_valid  = 1'b0;
    io_req_addr   = '0;
    checks++;
    if ({io_resp_valid, io_axi_mst_ar_chl_valid, io_req_ready} !== 3'b001) begin
      $display("FAIL %s after resp handshake {resp_valid,ar_valid,req_ready}: got=%b%b%b want=001",
               name, io_resp_valid, io_axi_mst_ar_chl_valid, io_req_ready);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ctrl_outs !== '0) begin
      $display("FAIL reset control outputs: got=%h want=0", ctrl_outs);
      errors++;
    end
    checks++;
    if (io_resp_data !== '0) begin
      $display("FAIL reset resp_data: got=%h want=0", io_resp_data);
      errors++;
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_req_ready, io_resp_valid, io_axi_mst_ar_chl_valid} !== 3'b100) begin
      $display("FAIL reset release {req_ready,resp_valid,ar_valid}: got=%b%b%b want=100",
               io_req_ready, io_resp_valid, io_axi_mst_ar_chl_valid);
      errors++;
    end
  endtask

  task automatic test_basic();
    run_line("basic", 32'h1000_0014, 32'h1000_0000, 0, -1, 7, 4'b0011, 1'b0, 10, 0);
  endtask

  task automatic test_stalls();
    run_line("stalls", 32'h1000_0014, 32'h1000_0000, 5, -1, 7, 4'b0011, 1'b0, 15, 3);
  endtask

  task automatic test_err_resp();
    run_line("err_resp", 32'h2000_005C, 32'h2000_0040, 0, 3, 7, 4'b0011, 1'b1, 10, 1);
  endtask

  task automatic test_early_rlast();
    run_line("early_rlast", 32'h3000_0008, 32'h3000_0000, 0, -1, 3, 4'b0011, 1'b1, 6, 0);
  endtask

  task automatic test_missing_rlast();
    run_line("missing_rlast", 32'h0000_00FC, 32'h0000_00E0, 0, -1, -1, 4'b0011, 1'b1, 10, 0);
  endtask

  task automatic test_bad_id();
`ifdef AXI_LINE_FILL_ID_CHECK_EN
    run_line("bad_id", 32'h6000_0020, 32'h6000_0020, 0, -1, 7, 4'b0101, 1'b1, 10, 0);
`else
    run_line("bad_id", 32'h6000_0020, 32'h6000_0020, 0, -1, 7, 4'b0101, 1'b0, 10, 0);
`endif
  endtask

  task automatic test_reset_mid_burst();
    io_req_valid = 1'b1;
    io_req_addr  = 32'h4000_0010;
    tick();
    io_req_valid = 1'b0;
    io_axi_mst_ar_chl_ready = 1'b1;
    tick();
    io_axi_mst_ar_chl_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      io_axi_mst_r_chl_valid      = 1'b1;
      io_axi_mst_r_chl_bits_rdata = 32'h4000_0000 + 32'(4 * i);
      tick();
    end
    idle_r();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ctrl_outs !== '0) begin
      $display("FAIL mid_reset control outputs: got=%h want=0", ctrl_outs);
      errors++;
    end
    checks++;
    if (io_resp_data !== '0) begin
      $display("FAIL mid_reset resp_data: got=%h want=0", io_resp_data);
      errors++;
    end
    tick();
    checks++;
    if ({io_req_ready, io_resp_valid} !== 2'b10) begin
      $display("FAIL mid_reset next cycle {req_ready,resp_valid}: got=%b%b want=10",
               io_req_ready, io_resp_valid);
      errors++;
    end
    run_line("after_reset", 32'h4000_0010, 32'h4000_0000, 0, -1, 7, 4'b0011, 1'b0, 10, 0);
  endtask

  initial begin
    reset                   = 1'b1;
    io_req_valid            = 1'b0;
    io_req_addr             = '0;
    io_resp_ready           = 1'b0;
    io_axi_mst_ar_chl_ready = 1'b0;
    idle_r();

    test_reset();
    test_basic();
    test_stalls();
    test_err_resp();
    test_early_rlast();
    test_missing_rlast();
    test_bad_id();
    test_reset_mid_burst();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
